// File: rtl/trace_pkg.sv
// Shared constants for the retire-event trace recorder: record layout,
// flag bit positions and the drop counter ceiling.
package trace_pkg;

    localparam int FLAG_REG   = 0;
    localparam int FLAG_LOAD  = 1;
    localparam int FLAG_STORE = 2;
    localparam int FLAG_HALT  = 3;

    localparam int REC_W = 56;

    localparam int MDATA_LSB = 0;
    localparam int ADDR_LSB  = 16;
    localparam int WDATA_LSB = 32;
    localparam int WREG_LSB  = 48;
    localparam int FLAGS_LSB = 52;

    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    function automatic logic [REC_W-1:0] packRecord(
        input logic [3:0]  flags,
        input logic [3:0]  writeReg,
        input logic [15:0] writeData,
        input logic [15:0] memAddr,
        input logic [15:0] memData
    );
        logic [REC_W-1:0] rec;
        rec = '0;
        rec[FLAGS_LSB +: 4]  = flags;
        rec[WREG_LSB  +: 4]  = writeReg;
        rec[WDATA_LSB +: 16] = writeData;
        rec[ADDR_LSB  +: 16] = memAddr;
        rec[MDATA_LSB +: 16] = memData;
        return rec;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO holding packed trace records; full/empty come from an
// extra pointer MSB so all DEPTH entries are usable.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = REC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty   = (wrPtr == rdPtr);
    assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPop   = pop && !empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign doPush  = push && (!full || doPop);
    assign popData = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
            if (doPop)  rdPtr <= rdPtr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
    end

endmodule

// File: rtl/trace_recorder.sv
// Retire-event recorder: packs each commit cycle into a trace record, queues it
// for a valid/ready consumer, and keeps cycle/instruction counters that stop at halt.
module trace_recorder
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reg_write,
    input  logic [3:0]       write_reg,
    input  logic [15:0]      write_data,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [15:0]      mem_addr,
    input  logic [15:0]      mem_wdata,
    input  logic [15:0]      mem_rdata,
    input  logic             hlt,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [REC_W-1:0] rd_record,
    output logic [31:0]      cycle_count,
    output logic [31:0]      inst_count,
    output logic             halted,
    output logic             overflow,
    output logic [15:0]      drop_count
);

    logic             eventCycle;
    logic             popFire;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [3:0]       recFlags;
    logic [3:0]       recReg;
    logic [15:0]      recWdata;
    logic [15:0]      recAddr;
    logic [15:0]      recMdata;
    logic [REC_W-1:0] newRecord;

    assign eventCycle = (reg_write || mem_read || mem_write || hlt) && !halted;
    assign rd_valid   = !fifoEmpty;
    assign popFire    = rd_valid && rd_ready;

    // Fields belonging to events that did not happen are forced to zero.
    always_comb begin
        recFlags             = '0;
        recFlags[FLAG_REG]   = reg_write;
        recFlags[FLAG_LOAD]  = mem_read;
        recFlags[FLAG_STORE] = mem_write;
        recFlags[FLAG_HALT]  = hlt;
        recReg   = reg_write ? write_reg  : 4'h0;
        recWdata = reg_write ? write_data : 16'h0000;
        recAddr  = (mem_read || mem_write) ? mem_addr : 16'h0000;
        if (mem_write)
            recMdata = mem_wdata;
        else if (mem_read)
            recMdata = mem_rdata;
        else
            recMdata = 16'h0000;
        newRecord = packRecord(recFlags, recReg, recWdata, recAddr, recMdata);
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (eventCycle),
        .pushData (newRecord),
        .pop      (rd_ready),
        .popData  (rd_record),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    // The halt cycle itself still counts; everything freezes from the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
            inst_count  <= '0;
            halted      <= 1'b0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (!halted) begin
                cycle_count <= cycle_count + 32'd1;
                if (hlt || reg_write || mem_write)
                    inst_count <= inst_count + 32'd1;
                if (hlt)
                    halted <= 1'b1;
            end
            if (eventCycle && fifoFull && !popFire) begin
                overflow <= 1'b1;
                if (drop_count != DROP_MAX)
                    drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_trace_recorder.sv
// Self-checking bench for trace_recorder: table-driven record checks, a
// scoreboard of expected records, and hand sequences for overflow, halt and reset.
module tb_trace_recorder;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic        rw;
        logic [3:0]  wreg;
        logic [15:0] wdata;
        logic        mr;
        logic        mw;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] rd;
        logic        hlt;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        rdy;
        logic [55:0] expRec;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        regWrite = 1'b0;
    logic [3:0]  writeReg = '0;
    logic [15:0] writeData = '0;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [15:0] memAddr = '0;
    logic [15:0] memWdata = '0;
    logic [15:0] memRdata = '0;
    logic        hltIn = 1'b0;
    logic        rdValid;
    logic        rdReady = 1'b0;
    logic [55:0] rdRecord;
    logic [31:0] cycleCount;
    logic [31:0] instCount;
    logic        haltedOut;
    logic        overflowOut;
    logic [15:0] dropCount;

    logic [55:0] expQ[$];
    logic [31:0] mCycle;
    logic [31:0] mInst;
    logic        mHalted;
    logic        mOverflow;
    logic [15:0] mDrop;

    int vectors = 0;
    int miscompares = 0;

    trace_recorder #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .reg_write   (regWrite),
        .write_reg   (writeReg),
        .write_data  (writeData),
        .mem_read    (memRead),
        .mem_write   (memWrite),
        .mem_addr    (memAddr),
        .mem_wdata   (memWdata),
        .mem_rdata   (memRdata),
        .hlt         (hltIn),
        .rd_valid    (rdValid),
        .rd_ready    (rdReady),
        .rd_record   (rdRecord),
        .cycle_count (cycleCount),
        .inst_count  (instCount),
        .halted      (haltedOut),
        .overflow    (overflowOut),
        .drop_count  (dropCount)
    );

    always #5 clk = ~clk;

    function automatic stim_t mkStim(
        input logic rw, input logic [3:0] wreg, input logic [15:0] wdata,
        input logic mr, input logic mw, input logic [15:0] addr,
        input logic [15:0] wd, input logic [15:0] rd, input logic hlt
    );
        stim_t s;
        s.rw = rw; s.wreg = wreg; s.wdata = wdata; s.mr = mr; s.mw = mw;
        s.addr = addr; s.wd = wd; s.rd = rd; s.hlt = hlt;
        return s;
    endfunction

    function automatic logic [55:0] expectRecord(input stim_t s);
        logic [15:0] md;
        md = s.mw ? s.wd : (s.mr ? s.rd : 16'h0000);
        return {s.hlt, s.mw, s.mr, s.rw,
                s.rw ? s.wreg : 4'h0,
                s.rw ? s.wdata : 16'h0000,
                (s.mr || s.mw) ? s.addr : 16'h0000,
                md};
    endfunction

    task automatic checkOutput(input string name, input logic [55:0] actual, input logic [55:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkCounters();
        checkOutput("cycle_count", 56'(cycleCount), 56'(mCycle));
        checkOutput("inst_count", 56'(instCount), 56'(mInst));
        checkOutput("halted", 56'(haltedOut), 56'(mHalted));
        checkOutput("overflow", 56'(overflowOut), 56'(mOverflow));
        checkOutput("drop_count", 56'(dropCount), 56'(mDrop));
    endtask

    task automatic doReset(input logic rdy);
        rst = 1'b1;
        regWrite = 0; writeReg = 0; writeData = 0; memRead = 0; memWrite = 0;
        memAddr = 0; memWdata = 0; memRdata = 0; hltIn = 0; rdReady = rdy;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.delete();
        mCycle = 0; mInst = 0; mHalted = 0; mOverflow = 0; mDrop = 0;
        checkOutput("rd_valid_after_reset", 56'(rdValid), 56'd0);
        checkCounters();
    endtask

    // One clock of stimulus: drive, check the presented record, advance the model.
    task automatic applyStimulus(input stim_t s, input logic rdy, input logic [55:0] expRec);
        logic pop;
        logic full;
        logic [55:0] head;
        regWrite = s.rw; writeReg = s.wreg; writeData = s.wdata;
        memRead = s.mr; memWrite = s.mw; memAddr = s.addr;
        memWdata = s.wd; memRdata = s.rd; hltIn = s.hlt; rdReady = rdy;
        @(negedge clk);
        checkOutput("rd_valid", 56'(rdValid), 56'(expQ.size() != 0));
        pop  = rdy && (expQ.size() != 0);
        full = (expQ.size() == DEPTH);
        if (pop) begin
            head = expQ.pop_front();
            checkOutput("rd_record", rdRecord, head);
        end
        if ((s.rw || s.mr || s.mw || s.hlt) && !mHalted) begin
            if (full && !pop) begin
                mOverflow = 1'b1;
                if (mDrop != 16'hFFFF) mDrop = mDrop + 16'd1;
            end else begin
                expQ.push_back(expRec);
            end
        end
        if (!mHalted) begin
            mCycle = mCycle + 32'd1;
            if (s.hlt || s.rw || s.mw) mInst = mInst + 32'd1;
            if (s.hlt) mHalted = 1'b1;
        end
        @(posedge clk);
        #1;
        checkCounters();
    endtask

    task automatic applyAuto(input stim_t s, input logic rdy);
        applyStimulus(s, rdy, expectRecord(s));
    endtask

    initial begin
        vec_t  vecs[8];
        stim_t idle;
        idle = mkStim(0, 4'h0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 0);

        vecs[0] = '{mkStim(1, 4'h3, 16'h1234, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0), 1'b1, 56'h13123400000000};
        vecs[1] = '{idle, 1'b1, 56'h0};
        vecs[2] = '{mkStim(1, 4'h1, 16'h0005, 0, 1, 16'h0040, 16'hBEEF, 16'h0000, 0), 1'b1, 56'h5100050040BEEF};
        vecs[3] = '{mkStim(0, 4'h7, 16'h7777, 1, 0, 16'h0010, 16'h0000, 16'h00AA, 0), 1'b1, 56'h200000001000AA};
        vecs[4] = '{mkStim(0, 4'h0, 16'h0000, 0, 1, 16'h1234, 16'h5678, 16'h9999, 0), 1'b1, 56'h40000012345678};
        vecs[5] = '{mkStim(1, 4'hF, 16'hFFFF, 0, 0, 16'hABCD, 16'h1111, 16'h2222, 0), 1'b1, 56'h1FFFFF00000000};
        vecs[6] = '{mkStim(0, 4'h0, 16'h0000, 1, 1, 16'h0022, 16'h3333, 16'h4444, 0), 1'b1, 56'h60000000223333};
        vecs[7] = '{mkStim(0, 4'h9, 16'h9999, 0, 0, 16'h5555, 16'h6666, 16'h7777, 0), 1'b1, 56'h0};

        doReset(1'b1);
        for (int i = 0; i < 8; i++)
            applyStimulus(vecs[i].s, vecs[i].rdy, vecs[i].expRec);
        for (int i = 0; i < 3; i++)
            applyAuto(idle, 1'b1);

        // Overflow: 20 writes into a stalled FIFO, then pop+push while full, then drain.
        doReset(1'b0);
        for (int i = 0; i < 20; i++)
            applyAuto(mkStim(1, 4'(i), 16'h1000 + 16'(i), 0, 0, 16'h0, 16'h0, 16'h0, 0), 1'b0);
        checkOutput("drop_count_after_fill", 56'(dropCount), 56'd4);
        checkOutput("overflow_after_fill", 56'(overflowOut), 56'd1);
        applyAuto(mkStim(1, 4'hA, 16'hCAFE, 0, 0, 16'h0, 16'h0, 16'h0, 0), 1'b1);
        checkOutput("drop_count_pop_push", 56'(dropCount), 56'd4);
        for (int i = 0; i < 18; i++)
            applyAuto(idle, 1'b1);
        checkOutput("rd_valid_drained", 56'(rdValid), 56'd0);

        // Halt at cycle 10 after seven counted instructions.
        doReset(1'b1);
        applyAuto(mkStim(1, 4'h1, 16'h0001, 0, 0, 16'h0, 16'h0, 16'h0, 0), 1'b1);
        applyAuto(mkStim(1, 4'h2, 16'h0002, 0, 0, 16'h0, 16'h0, 16'h0, 0), 1'b1);
        applyAuto(idle, 1'b1);
        applyAuto(mkStim(0, 4'h0, 16'h0000, 0, 1, 16'h0100, 16'h00FF, 16'h0, 0), 1'b1);
        applyAuto(mkStim(1, 4'h5, 16'h0005, 0, 0, 16'h0, 16'h0, 16'h0, 0), 1'b1);
        applyAuto(mkStim(0, 4'h0, 16'h0000, 1, 0, 16'h0200, 16'h0, 16'h0042, 0), 1'b1);
        applyAuto(mkStim(1, 4'h7, 16'h0007, 0, 0, 16'h0, 16'h0, 16'h0, 0), 1'b1);
        applyAuto(mkStim(1, 4'h8, 16'h0008, 0, 0, 16'h0, 16'h0, 16'h0, 0), 1'b1);
        applyAuto(mkStim(1, 4'h9, 16'h0009, 0, 1, 16'h0300, 16'h0999, 16'h0, 0), 1'b1);
        applyStimulus(mkStim(0, 4'h0, 16'h0000, 0, 0, 16'h0, 16'h0, 16'h0, 1), 1'b1, 56'h80000000000000);
        for (int i = 0; i < 4; i++)
            applyAuto(mkStim(1, 4'hC, 16'h0C0C, 0, 0, 16'h0, 16'h0, 16'h0, 0), 1'b1);
        checkOutput("cycle_count_frozen", 56'(cycleCount), 56'd10);
        checkOutput("inst_count_frozen", 56'(instCount), 56'd8);
        checkOutput("halted_sticky", 56'(haltedOut), 56'd1);

        // Reset while records are still queued.
        doReset(1'b0);
        for (int i = 0; i < 3; i++)
            applyAuto(mkStim(1, 4'(i), 16'hD000 + 16'(i), 0, 0, 16'h0, 16'h0, 16'h0, 0), 1'b0);
        checkOutput("rd_valid_before_reset", 56'(rdValid), 56'd1);
        doReset(1'b1);
        applyAuto(idle, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trace_recorder.md
# trace_recorder

Synthesizable retire-event recorder that sits directly downstream of the CPU's writeback and memory stages, consuming the same per-cycle commit signals the phase-2 testbench traces. Each cycle with a register write, load, store or halt produces one packed trace record into an internal FIFO, drained by a valid/ready port. It also keeps cycle and instruction counters that stop at halt, so FPGA runs produce the same REG/LOAD/STORE and SIMLOG data as simulation.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥2
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- reg_write  input  1  register file written this cycle
- write_reg  input  4  destination register
- write_data  input  16  register write data
- mem_read  input  1  load in memory stage this cycle
- mem_write  input  1  store in memory stage this cycle
- mem_addr  input  16  memory address
- mem_wdata  input  16  store data (written to memory)
- mem_rdata  input  16  load data (read from memory)
- hlt  input  1  halt reached memory/writeback
- rd_valid  output  1  record available
- rd_ready  input  1  consumer accepts record
- rd_record  output  56  {flags[3:0]=halt,store,load,reg; write_reg[3:0]; write_data[15:0]; mem_addr[15:0]; mem_data[15:0]}
- cycle_count  output  32  cycles since reset release
- inst_count  output  32  retired instructions
- halted  output  1  sticky halt seen
- overflow  output  1  sticky: at least one record dropped
- drop_count  output  16  dropped records, saturating

## Operation
- Event cycle: any of reg_write, mem_read, mem_write, hlt high while halted=0.
- One record per event cycle; flags mirror the four inputs. mem_data = mem_wdata if mem_write, else mem_rdata if mem_read, else 0. Fields of deasserted events are zero (write_reg/write_data zero if !reg_write; mem_addr zero if neither mem flag).
- inst_count += 1 when halted=0 and (hlt | reg_write | mem_write). mem_read alone does not count.
- cycle_count += 1 every cycle while halted=0, including the halt cycle.
- Halt: the hlt cycle's record is pushed normally (halt flag set); halted sets next edge. While halted: no pushes, counters frozen, draining continues. Only rst clears halted.
- FIFO full at push: record dropped, overflow set, drop_count += 1 saturating at 0xFFFF. Full with rd_valid & rd_ready same cycle: pop and push both happen, no drop.
- Empty: rd_valid=0, rd_record holds last value (don't care).
- Pointers wrap modulo DEPTH; full/empty via extra pointer MSB.
- Reset values: rd_valid 0, cycle_count 0, inst_count 0, halted 0, overflow 0, drop_count 0, FIFO empty. Reset mid-operation discards all stored records immediately.

## Timing
- Push latency: event on edge N → rd_valid=1 after edge N (available in cycle N+1) if FIFO was empty.
- Pop: record consumed on an edge with rd_valid & rd_ready; next record presented the following cycle, no bubble.
- Counters registered; values reflect events up to the previous edge.
- rd_valid does not depend combinationally on rd_ready; rd_record stable while rd_valid & !rd_ready.
- rst high on an edge overrides every concurrent event, push and pop.

## Structure
- Package trace_pkg: flag bit positions (FLAG_REG=0, FLAG_LOAD=1, FLAG_STORE=2, FLAG_HALT=3), REC_W=56, field offset constants, DROP_MAX.
- Sub-module trace_fifo (parameter DEPTH, width REC_W): synchronous FIFO with push/pop/full/empty; the top holds record packing, counters, halt and drop logic.

## Test plan
- Reset then reg_write r3=0x1234 one cycle, rd_ready=1 → one record flags=0001, reg 3, data 0x1234; inst_count=1, cycle_count increments every cycle.
- Store addr 0x0040 data 0xBEEF plus reg_write r1=0x0005 same cycle → single record flags=0101, mem_data 0xBEEF; inst_count +1 (not +2).
- Load addr 0x0010 returns 0x00AA, no reg_write → flags=0010, mem_data 0x00AA; inst_count unchanged.
- DEPTH=16, rd_ready=0, 20 consecutive reg_write cycles → 16 records held, drop_count=4, overflow=1; then rd_ready=1 drains exactly 16 in order.
- Full FIFO with rd_ready=1 and a new event same cycle → no drop, occupancy stays 16, drop_count unchanged.
- hlt after 7 counted instructions at cycle 10 → halt record last, halted=1, cycle_count=10 and inst_count=8 frozen despite later reg_write; rst mid-drain → rd_valid=0, all counters 0 next cycle.
